// File: rtl/perceptron_pkg.sv
// Shared constants and helpers for the perceptron_multi integrate-and-fire neuron.
package perceptron_pkg;

  localparam int N_INPUTS_DEF      = 2;
  localparam int IN_W_DEF          = 4;
  localparam int WEIGHT_W_DEF      = 4;
  localparam int STATE_W_DEF       = 8;
  localparam int LEAK_SHIFT_DEF    = 1;
  localparam int REFRAC_CYCLES_DEF = 2;
  localparam int THRESH_RST_DEF    = 127;

  // Widest accumulator the saturation helper handles.
  localparam int SAT_W = 64;

  function automatic int thresh_addr(input int n_inputs);
    return n_inputs;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clamp an accumulator to the largest value representable in state_w bits.
  function automatic logic [SAT_W-1:0] sat_state(input logic [SAT_W-1:0] acc, input int state_w);
    logic [SAT_W-1:0] max_v;
    max_v = (SAT_W'(1) << state_w) - SAT_W'(1);
    if (acc > max_v) begin
      return max_v;
    end else begin
      return acc;
    end
  endfunction

endpackage

// File: rtl/perceptron_multi_if.sv
// Data and configuration bus of perceptron_multi; master drives inputs, slave is the neuron.
interface perceptron_multi_if
  import perceptron_pkg::*;
#(
  parameter int N_INPUTS = N_INPUTS_DEF,
  parameter int IN_W     = IN_W_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int STATE_W  = STATE_W_DEF
) ();

  localparam int ADDR_W = $clog2(N_INPUTS + 1);
  localparam int CFG_W  = max_int(WEIGHT_W, STATE_W);

  logic                     in_valid;
  logic [N_INPUTS*IN_W-1:0] v_in;
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [ADDR_W-1:0]        cfg_addr;
  logic [CFG_W-1:0]         cfg_data;
  logic [STATE_W-1:0]       state;
  logic                     v_out;
  logic                     refrac;

  modport master (
    output in_valid, v_in, cfg_valid, cfg_addr, cfg_data,
    input  cfg_ready, state, v_out, refrac
  );

  modport slave (
    input  in_valid, v_in, cfg_valid, cfg_addr, cfg_data,
    output cfg_ready, state, v_out, refrac
  );

endinterface

// File: rtl/perceptron_weight_bank.sv
// Runtime-writable weights and firing threshold for perceptron_multi.
module perceptron_weight_bank
  import perceptron_pkg::*;
#(
  parameter int N_INPUTS   = N_INPUTS_DEF,
  parameter int WEIGHT_W   = WEIGHT_W_DEF,
  parameter int STATE_W    = STATE_W_DEF,
  parameter int THRESH_RST = THRESH_RST_DEF,
  parameter int ADDR_W     = $clog2(N_INPUTS + 1),
  parameter int CFG_W      = max_int(WEIGHT_W, STATE_W)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [CFG_W-1:0]             wr_data,
  output logic [N_INPUTS*WEIGHT_W-1:0] weights,
  output logic [STATE_W-1:0]           thresh
);

  localparam logic [ADDR_W-1:0] T_ADDR = ADDR_W'(thresh_addr(N_INPUTS));

  logic [WEIGHT_W-1:0] weight_q [N_INPUTS];
  logic [WEIGHT_W-1:0] weight_d [N_INPUTS];
  logic [STATE_W-1:0]  thresh_q;
  logic [STATE_W-1:0]  thresh_d;

  // Addresses above the threshold slot match nothing and are dropped.
  always_comb begin
    weight_d = weight_q;
    thresh_d = thresh_q;
    if (wr_en) begin
      if (wr_addr == T_ADDR) begin
        thresh_d = wr_data[STATE_W-1:0];
      end else begin
        for (int i = 0; i < N_INPUTS; i++) begin
          if (wr_addr == ADDR_W'(i)) begin
            weight_d[i] = wr_data[WEIGHT_W-1:0];
          end else begin
            weight_d[i] = weight_q[i];
          end
        end
      end
    end else begin
      thresh_d = thresh_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        weight_q[i] <= WEIGHT_W'(1);
      end
      thresh_q <= STATE_W'(THRESH_RST);
    end else begin
      weight_q <= weight_d;
      thresh_q <= thresh_d;
    end
  end

  always_comb begin
    weights = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      weights[i*WEIGHT_W +: WEIGHT_W] = weight_q[i];
    end
    thresh = thresh_q;
  end

endmodule

// File: rtl/perceptron_multi.sv
// N-input leaky integrate-and-fire neuron with saturating membrane state.
// Refractory hold after each spike is enabled by defining PERCEPTRON_REFRAC_EN.
module perceptron_multi
  import perceptron_pkg::*;
#(
  parameter int N_INPUTS      = N_INPUTS_DEF,
  parameter int IN_W          = IN_W_DEF,
  parameter int WEIGHT_W      = WEIGHT_W_DEF,
  parameter int STATE_W       = STATE_W_DEF,
  parameter int LEAK_SHIFT    = LEAK_SHIFT_DEF,
  parameter int REFRAC_CYCLES = REFRAC_CYCLES_DEF,
  parameter int THRESH_RST    = THRESH_RST_DEF
) (
  input logic               clk,
  input logic               reset,
  perceptron_multi_if.slave bus
);

  localparam int ADDR_W = $clog2(N_INPUTS + 1);
  localparam int CFG_W  = max_int(WEIGHT_W, STATE_W);
  localparam int ACC_W  = STATE_W + IN_W + WEIGHT_W + $clog2(N_INPUTS);

  logic [N_INPUTS*WEIGHT_W-1:0] weights;
  logic [STATE_W-1:0]           thresh;
  logic                         cfg_wr;
  logic [ACC_W-1:0]             mac_sum;
  logic [ACC_W-1:0]             acc;
  logic [STATE_W-1:0]           acc_sat;
  logic                         fire;
  logic                         busy;

  logic [STATE_W-1:0] state_q, state_d;
  logic               v_out_q, v_out_d;

  assign bus.cfg_ready = ~reset;
  assign cfg_wr        = bus.cfg_valid & ~reset;

  perceptron_weight_bank #(
    .N_INPUTS  (N_INPUTS),
    .WEIGHT_W  (WEIGHT_W),
    .STATE_W   (STATE_W),
    .THRESH_RST(THRESH_RST),
    .ADDR_W    (ADDR_W),
    .CFG_W     (CFG_W)
  ) u_bank (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (cfg_wr),
    .wr_addr(bus.cfg_addr),
    .wr_data(bus.cfg_data),
    .weights(weights),
    .thresh (thresh)
  );

  // Weighted sum, leak and saturation, all at full accumulator width.
  always_comb begin
    mac_sum = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      mac_sum = mac_sum + (ACC_W'(bus.v_in[i*IN_W +: IN_W]) * ACC_W'(weights[i*WEIGHT_W +: WEIGHT_W]));
    end
    acc     = ACC_W'(state_q >> LEAK_SHIFT) + (bus.in_valid ? mac_sum : '0);
    acc_sat = STATE_W'(sat_state(SAT_W'(acc), STATE_W));
    fire    = (acc_sat >= thresh);
  end

`ifdef PERCEPTRON_REFRAC_EN
  localparam int CNT_W = $clog2(REFRAC_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             refrac_q, refrac_d;

  assign busy = (cnt_q != '0);

  always_comb begin
    if (busy) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (fire) begin
      cnt_d = CNT_W'(REFRAC_CYCLES);
    end else begin
      cnt_d = '0;
    end
    refrac_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      refrac_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      refrac_q <= refrac_d;
    end
  end

  assign bus.refrac = refrac_q;
`else
  assign busy       = 1'b0;
  assign bus.refrac = (REFRAC_CYCLES < 0);
`endif

  always_comb begin
    if (busy) begin
      state_d = '0;
      v_out_d = 1'b0;
    end else if (fire) begin
      state_d = '0;
      v_out_d = 1'b1;
    end else begin
      state_d = acc_sat;
      v_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
      v_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_out_q <= v_out_d;
    end
  end

  assign bus.state = state_q;
  assign bus.v_out = v_out_q;

endmodule

// File: tb/tb_perceptron_multi.sv
// Scoreboard bench for perceptron_multi at default parameters.
module tb_perceptron_multi;
  import perceptron_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  perceptron_multi_if bus ();

  perceptron_multi dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [7:0] st;
    logic       vo;
    logic       rf;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  int m_state = 0;
  int m_cnt   = 0;
  int m_th    = 127;
  int m_w[2]  = '{1, 1};

`ifdef PERCEPTRON_REFRAC_EN
  localparam int M_REFRAC = 2;
`else
  localparam int M_REFRAC = 0;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock of stimulus: the reference model predicts, the DUT is checked after the edge.
  task automatic step(input bit rst, input bit vld, input int x0, input int x1,
                      input bit cv, input int addr, input int data);
    int   acc;
    int   sat;
    int   ns;
    int   nc;
    bit   nv;
    exp_t e;
    @(negedge clk);
    reset         = rst;
    bus.in_valid  = vld;
    bus.v_in      = {4'(x1), 4'(x0)};
    bus.cfg_valid = cv;
    bus.cfg_addr  = 2'(addr);
    bus.cfg_data  = 8'(data);
    #1;
    check_val("cfg_ready", {31'd0, bus.cfg_ready}, rst ? 32'd0 : 32'd1);
    if (rst) begin
      ns = 0; nv = 1'b0; nc = 0;
    end else if (m_cnt != 0) begin
      ns = 0; nv = 1'b0; nc = m_cnt - 1;
    end else begin
      acc = (m_state >> 1) + (vld ? (m_w[0] * x0 + m_w[1] * x1) : 0);
      sat = (acc > 255) ? 255 : acc;
      if (sat >= m_th) begin
        ns = 0; nv = 1'b1; nc = M_REFRAC;
      end else begin
        ns = sat; nv = 1'b0; nc = 0;
      end
    end
    if (rst) begin
      m_w[0] = 1; m_w[1] = 1; m_th = 127;
    end else if (cv) begin
      if (addr < 2) m_w[addr] = data & 15;
      else if (addr == 2) m_th = data & 255;
    end
    m_state = ns;
    m_cnt   = nc;
    e.st = 8'(ns);
    e.vo = nv;
    e.rf = (nc != 0);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("state",  {24'd0, bus.state},  {24'd0, e.st});
    check_val("v_out",  {31'd0, bus.v_out},  {31'd0, e.vo});
    check_val("refrac", {31'd0, bus.refrac}, {31'd0, e.rf});
  endtask

  task automatic run_to_spike();
    step(0, 0, 0, 0, 1, 2, 50);
    step(0, 1, 15, 15, 0, 0, 0);
    check_val("if_s1", {24'd0, bus.state}, 32'd30);
    step(0, 1, 15, 15, 0, 0, 0);
    check_val("if_s2", {24'd0, bus.state}, 32'd45);
    step(0, 1, 15, 15, 0, 0, 0);
    check_val("if_fire", {31'd0, bus.v_out}, 32'd1);
    check_val("if_zero", {24'd0, bus.state}, 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.v_in      = '0;
    bus.cfg_valid = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check_val("rst_state", {24'd0, bus.state}, 32'd0);
    check_val("rst_vout", {31'd0, bus.v_out}, 32'd0);

    run_to_spike();
`ifdef PERCEPTRON_REFRAC_EN
    check_val("rf_spike", {31'd0, bus.refrac}, 32'd1);
    step(0, 1, 15, 15, 0, 0, 0);
    check_val("rf_hold1", {31'd0, bus.refrac}, 32'd1);
    step(0, 1, 15, 15, 0, 0, 0);
    check_val("rf_end", {31'd0, bus.refrac}, 32'd0);
    check_val("rf_end_state", {24'd0, bus.state}, 32'd0);
`endif
    step(0, 1, 15, 15, 0, 0, 0);
    check_val("resume", {24'd0, bus.state}, 32'd30);

    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 2, 100);
    for (int i = 0; i < 8; i++) step(0, 1, 15, 15, 0, 0, 0);
    check_val("leak_conv", {24'd0, bus.state}, 32'd59);
    check_val("leak_nofire", {31'd0, bus.v_out}, 32'd0);

    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 15);
    step(0, 0, 0, 0, 1, 1, 15);
    step(0, 0, 0, 0, 1, 2, 255);
    step(0, 1, 15, 15, 0, 0, 0);
    check_val("sat_fire", {31'd0, bus.v_out}, 32'd1);

    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 10, 0, 1, 0, 0);
    check_val("coll_old_w", {24'd0, bus.state}, 32'd10);
    step(0, 1, 10, 0, 0, 0, 0);
    check_val("coll_new_w", {24'd0, bus.state}, 32'd5);

    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check_val("thr0_fire", {31'd0, bus.v_out}, 32'd1);

    step(1, 0, 0, 0, 0, 0, 0);
    run_to_spike();
    step(1, 1, 15, 15, 0, 0, 0);
    check_val("rr_refrac", {31'd0, bus.refrac}, 32'd0);
    check_val("rr_vout", {31'd0, bus.v_out}, 32'd0);
    step(0, 1, 15, 15, 0, 0, 0);
    check_val("rr_weights", {24'd0, bus.state}, 32'd30);
    for (int i = 0; i < 6; i++) step(0, 1, 15, 15, 0, 0, 0);
    check_val("rr_thresh", {24'd0, bus.state}, 32'd59);

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, 15),
           $urandom_range(0, 15), ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
           $urandom_range(0, 255));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/perceptron_multi.md
# perceptron_multi

Parametrised successor to the two-input integrate-and-fire perceptron used in our Tiny Tapeout tops. It takes N unsigned input channels, weights each one, and accumulates the weighted sum into a leaky membrane state. It emits a one-cycle spike on threshold crossing, then holds an optional refractory period. Weights and threshold are runtime-writable through a valid/ready config port, so the `tt_um_*` wrapper can drive it from `uio_in`.

## Interface
- `N_INPUTS`, default 2: number of input channels (≥1)
- `IN_W`, default 4: width of each input channel, unsigned
- `WEIGHT_W`, default 4: width of each weight, unsigned
- `STATE_W`, default 8: membrane state width
- `LEAK_SHIFT`, default 1: leak as right-shift amount; 0 gives a perfect integrator
- `REFRAC_CYCLES`, default 2: refractory length in cycles (≥1)
- `THRESH_RST`, default 127: threshold value after reset
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  qualifies `v_in` this cycle
- `v_in`  in  N_INPUTS*IN_W  packed channels; channel i is `[i*IN_W +: IN_W]`
- `cfg_valid`  in  1  config write request
- `cfg_ready`  out  1  config write accepted when high together with `cfg_valid`
- `cfg_addr`  in  $clog2(N_INPUTS+1)  0..N_INPUTS-1 selects a weight; N_INPUTS selects the threshold
- `cfg_data`  in  max(WEIGHT_W,STATE_W)  write data, LSB-aligned
- `state`  out  STATE_W  registered membrane state
- `v_out`  out  1  registered spike, one cycle wide
- `refrac`  out  1  high while refractory (constant 0 without the macro)

## Operation
- Reset values:
  - `state`, `v_out`, `refrac` and the refractory counter are all 0.
  - All weights are 1; threshold = `THRESH_RST`.
  - `cfg_ready` is 0 during the reset cycle and 1 on every other cycle.
- Integration on each cycle when not refractory:
  - `acc = (state >> LEAK_SHIFT) + (in_valid ? Σ w_i*x_i : 0)`.
  - `acc` is computed at full width: `STATE_W + IN_W + WEIGHT_W + $clog2(N_INPUTS)` bits.
  - `acc` saturates to `2^STATE_W-1`; there is no wrap-around.
- Fire: if the saturated `acc` ≥ threshold, then next cycle `v_out`=1, `state`=0 and the refractory counter = `REFRAC_CYCLES`.
- No fire: `state` = saturated `acc`, `v_out` = 0.
- Refractory:
  - While the counter is nonzero, `state` holds 0, inputs are ignored, `v_out`=0 and `refrac`=1.
  - The counter decrements once per cycle; integration resumes on the cycle after it reaches 0.
- Config write: when `cfg_valid && cfg_ready`, write `cfg_data` to the addressed register.
  - Weights take the low `WEIGHT_W` bits; the threshold takes the low `STATE_W` bits.
  - `cfg_addr` > N_INPUTS is accepted and ignored.
- Threshold 0: the block fires on every non-refractory cycle.

## Timing
- Input to `state`/`v_out`: 1 cycle; the registered outputs change only on the `clk` edge.
- Spike-to-resume: `REFRAC_CYCLES` cycles of ignored input; the first integrating edge is `REFRAC_CYCLES+1` edges after the spike edge.
- Config vs. integration in the same cycle: the integration uses the old weight/threshold; the new value applies from the next cycle.
- Reset mid-operation (integrating or refractory): all registers return to reset values on that edge; no spike is emitted.

## Configuration
- `PERCEPTRON_REFRAC_EN` defined: the refractory counter and `refrac` output behave as above.
- Undefined:
  - `REFRAC_CYCLES` is ignored and `refrac` is tied to 0.
  - After a spike, `state`=0 and integration resumes on the very next cycle.

## Structure
- Package `perceptron_pkg` holds:
  - default parameter constants;
  - the threshold-address helper (`THRESH_ADDR = N_INPUTS`);
  - a `sat_state` function (saturating truncation to `STATE_W`).
- Sub-module `perceptron_weight_bank`:
  - stores N_INPUTS weights plus the threshold and decodes config writes;
  - exposes the packed weights and the threshold combinationally.
- The top level holds the MAC/leak datapath, the fire compare and the refractory counter.

## Test plan
All scenarios use default parameters with the macro defined.
- **Reset:** hold `reset` 2 cycles → `state`=0, `v_out`=0, `refrac`=0, `cfg_ready`=0 then 1.
- **Integrate and fire:**
  - Stimulus: write threshold=50; then `in_valid`=1, x0=x1=15, weights 1.
  - `state` sequence is 30, 45; on the 3rd edge `acc`=52 gives `v_out`=1 and `state`=0.
  - `refrac`=1 for 2 cycles, then `state`=30.
- **Leak / no fire:** threshold=100 with the same inputs → `state` converges to 30,45,52,56,58,59,59… and `v_out` stays 0.
- **Saturation:** write both weights=15 and threshold=255; x0=x1=15 → `acc`=450 saturates to 255 ≥ 255, so fire on the 1st edge.
- **Config collision:** write w0=0 in the same cycle as x0=10, x1=0 → that edge still adds 10; the following edge adds 0.
- **Reset during refractory:** assert `reset` on the cycle after the spike → counter=0, `refrac`=0, weights back to 1, threshold=127.
